// File: rtl/ssram_arb2.sv
// Two-initiator arbiter onto a single SSRAM-style target: zero-latency request mux with
// round-robin/lock arbitration, in-order owner FIFO for response routing, orphan detection.
module ssram_arb2 #(
  parameter int C_OSTD_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  // initiator 0: instruction, read-only
  output logic        i0reqready_o,
  input  logic        i0reqvalid_i,
  input  logic [31:0] i0reqaddr_i,
  input  logic        i0rspready_i,
  output logic        i0rspvalid_o,
  output logic        i0rsprerr_o,
  output logic [31:0] i0rspdata_o,
  // initiator 1: data
  output logic        i1reqready_o,
  input  logic        i1reqvalid_i,
  input  logic        i1reqdvalid_i,
  input  logic [1:0]  i1reqsize_i,
  input  logic [31:0] i1reqaddr_i,
  input  logic [31:0] i1reqdata_i,
  input  logic        i1rspready_i,
  output logic        i1rspvalid_o,
  output logic        i1rsprerr_o,
  output logic [31:0] i1rspdata_o,
  // target
  input  logic        treqready_i,
  output logic        treqvalid_o,
  output logic        treqdvalid_o,
  output logic [1:0]  treqsize_o,
  output logic [31:0] treqaddr_o,
  output logic [31:0] treqdata_o,
  output logic        trspready_o,
  input  logic        trspvalid_i,
  input  logic        trsprerr_i,
  input  logic [31:0] trspdata_i,
  output logic        orphan_o
);

  localparam int PW = $clog2(C_OSTD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} arb_st_t;

  typedef struct packed {
    logic        dvalid;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  arb_st_t                 locked_q;
  logic                    lockown_q;
  logic                    last_q;
  logic [C_OSTD_DEPTH-1:0] own_mem;
  logic [PW-1:0]           wptr_q;
  logic [PW-1:0]           rptr_q;
  logic [CW-1:0]           cnt_q;
  logic                    orphan_q;

  logic act, own, gvalid, full, empty, head;
  logic push, pop, rsp_acc, orphan_set;
  req_t req0, req1, treq;

  // reset and clock-enable both silence every handshake output
  assign act   = clk_en_i & resetb_i;
  assign full  = (cnt_q == CW'(C_OSTD_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = own_mem[rptr_q];

  always_comb begin
    own = 1'b0;
    if (locked_q == LOCKED)
      own = lockown_q;
    else if (i0reqvalid_i && i1reqvalid_i)
      own = ~last_q;
    else if (i1reqvalid_i)
      own = 1'b1;
  end

  always_comb begin
    req0 = '{dvalid: 1'b0, size: 2'b10, addr: i0reqaddr_i, data: 32'h0};
    req1 = '{dvalid: i1reqdvalid_i, size: i1reqsize_i, addr: i1reqaddr_i, data: i1reqdata_i};
    treq = own ? req1 : req0;
  end

  assign gvalid       = own ? i1reqvalid_i : i0reqvalid_i;
  assign treqvalid_o  = act & gvalid & ~full;
  assign treqdvalid_o = treq.dvalid;
  assign treqsize_o   = treq.size;
  assign treqaddr_o   = treq.addr;
  assign treqdata_o   = treq.data;

  // full blocks acceptance even when a pop lands this cycle: no response-to-request path
  assign i0reqready_o = act & ~own & treqready_i & ~full;
  assign i1reqready_o = act &  own & treqready_i & ~full;
  assign push         = treqvalid_o & treqready_i;

  assign trspready_o  = act & (empty | (head ? i1rspready_i : i0rspready_i));
  assign i0rspvalid_o = act & ~empty & ~head & trspvalid_i;
  assign i1rspvalid_o = act & ~empty &  head & trspvalid_i;
  assign i0rsprerr_o  = ~empty & ~head & trsprerr_i;
  assign i1rsprerr_o  = ~empty &  head & trsprerr_i;
  assign i0rspdata_o  = (~empty & ~head) ? trspdata_i : 32'h0;
  assign i1rspdata_o  = (~empty &  head) ? trspdata_i : 32'h0;

  assign rsp_acc    = trspvalid_i & trspready_o;
  assign pop        = rsp_acc & ~empty;
  assign orphan_set = rsp_acc & empty;
  assign orphan_o   = orphan_q;

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      locked_q  <= OPEN;
      lockown_q <= 1'b0;
      last_q    <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      orphan_q  <= 1'b0;
    end else if (clk_en_i) begin
      case (locked_q)
        OPEN: if (treqvalid_o && !treqready_i) begin
          locked_q  <= LOCKED;
          lockown_q <= own;
        end
        LOCKED: if (push) locked_q <= OPEN;
        default: locked_q <= OPEN;
      endcase
      if (push) begin
        last_q <= own;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (orphan_set) orphan_q <= 1'b1;
    end
  end

  // owner storage needs no reset: entries are only read while the count says they are live
  always_ff @(posedge clk_i) begin
    if (resetb_i && clk_en_i && push) own_mem[wptr_q] <= own;
  end

endmodule
